// File: rtl/zeroriscy_hpm_counters.sv
// Hardware performance monitor: N_CNT event counters with selectable sources,
// an inhibit mask and sticky overflow flags that can raise an interrupt.
module zeroriscy_hpm_counters #(
    parameter int N_CNT     = 4,
    parameter int CNT_WIDTH = 40,
    parameter int N_EVENTS  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [1:0]          csr_op_i,
    input  logic [31:0]         csr_wdata_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] event_i,
    output logic [N_CNT-1:0]    ovf_status_o,
    output logic                ovf_irq_o
);
    localparam int HI_W = CNT_WIDTH - 32;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [CNT_WIDTH-1:0] cnt_q [N_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [N_CNT];
    logic [4:0]           sel_q [N_CNT];
    logic [4:0]           sel_d [N_CNT];
    logic [N_CNT-1:0]     inhibit_q, inhibit_d;
    logic [N_CNT-1:0]     ovf_status_q, ovf_status_d;
    logic [N_CNT-1:0]     ovf_enable_q, ovf_enable_d;
    logic [N_CNT-1:0]     inc, ovf_set;
    logic [N_EVENTS-1:0]  ev_q;
    logic [31:0]          ev_ext;
    logic                 we;

    function automatic logic [31:0] csr_wval(input logic [31:0] q, input logic [31:0] w,
                                             input logic [1:0] op);
        case (op)
            OP_WRITE: return w;
            OP_SET:   return q | w;
            OP_CLEAR: return q & ~w;
            default:  return q;
        endcase
    endfunction

    // Selector 0 and selectors above N_EVENTS land on constant-zero bits
    assign ev_ext = 32'({ev_q, 1'b0});
    assign we     = csr_access_i && (csr_op_i != OP_NONE);

    always_comb begin
        csr_hit_o   = 1'b0;
        csr_rdata_o = '0;
        if (csr_addr_i == 12'h320) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = 32'(inhibit_q) << 3;
        end
        if (csr_addr_i == 12'h7C0) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = 32'(ovf_status_q);
        end
        if (csr_addr_i == 12'h7C1) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = 32'(ovf_enable_q);
        end
        for (int i = 0; i < N_CNT; i++) begin
            if (csr_addr_i == 12'h323 + 12'(i)) begin
                csr_hit_o   = 1'b1;
                csr_rdata_o = 32'(sel_q[i]);
            end
            if (csr_addr_i == 12'hB03 + 12'(i)) begin
                csr_hit_o   = 1'b1;
                csr_rdata_o = cnt_q[i][31:0];
            end
            if (csr_addr_i == 12'hB83 + 12'(i)) begin
                csr_hit_o   = 1'b1;
                csr_rdata_o = 32'(cnt_q[i][CNT_WIDTH-1:32]);
            end
        end
        if (!csr_access_i) begin
            csr_hit_o   = 1'b0;
            csr_rdata_o = '0;
        end
    end

    always_comb begin
        inc     = '0;
        ovf_set = '0;
        for (int i = 0; i < N_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
            inc[i]   = ev_ext[sel_q[i]] & ~inhibit_q[i];
            if (we && csr_addr_i == 12'h323 + 12'(i))
                sel_d[i] = 5'(csr_wval(32'(sel_q[i]), csr_wdata_i, csr_op_i));
            // A CSR write to either half swallows a coincident increment
            if (we && csr_addr_i == 12'hB03 + 12'(i)) begin
                cnt_d[i][31:0] = csr_wval(cnt_q[i][31:0], csr_wdata_i, csr_op_i);
            end else if (we && csr_addr_i == 12'hB83 + 12'(i)) begin
                cnt_d[i][CNT_WIDTH-1:32] =
                    HI_W'(csr_wval(32'(cnt_q[i][CNT_WIDTH-1:32]), csr_wdata_i, csr_op_i));
            end else if (inc[i]) begin
                cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
                ovf_set[i] = &cnt_q[i];
            end
        end

        inhibit_d = inhibit_q;
        if (we && csr_addr_i == 12'h320)
            inhibit_d = N_CNT'(csr_wval(32'(inhibit_q) << 3, csr_wdata_i, csr_op_i) >> 3);

        ovf_enable_d = ovf_enable_q;
        if (we && csr_addr_i == 12'h7C1)
            ovf_enable_d = N_CNT'(csr_wval(32'(ovf_enable_q), csr_wdata_i, csr_op_i));

        // Hardware set is OR-ed in last so it beats a same-cycle software clear
        ovf_status_d = ovf_status_q;
        if (we && csr_addr_i == 12'h7C0)
            ovf_status_d = N_CNT'(csr_wval(32'(ovf_status_q), csr_wdata_i, csr_op_i));
        ovf_status_d = ovf_status_d | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            inhibit_q    <= '0;
            ovf_status_q <= '0;
            ovf_enable_q <= '0;
            ev_q         <= '0;
            ovf_irq_o    <= 1'b0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            inhibit_q    <= inhibit_d;
            ovf_status_q <= ovf_status_d;
            ovf_enable_q <= ovf_enable_d;
            ev_q         <= event_i;
            ovf_irq_o    <= |(ovf_status_q & ovf_enable_q);
        end
    end

    assign ovf_status_o = ovf_status_q;

endmodule

// File: tb/tb_zeroriscy_hpm_counters.sv
// Directed bench for zeroriscy_hpm_counters (N_CNT=4, CNT_WIDTH=40, N_EVENTS=16).
module tb_zeroriscy_hpm_counters;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_access;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic [15:0] event_in;
    logic [3:0]  ovf_status;
    logic        ovf_irq;
    int          n_tests = 0;
    int          n_fail  = 0;

    zeroriscy_hpm_counters #(.N_CNT(4), .CNT_WIDTH(40), .N_EVENTS(16)) dut (
        .clk(clk), .rst_n(rst_n), .csr_access_i(csr_access), .csr_addr_i(csr_addr),
        .csr_op_i(csr_op), .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
        .csr_hit_o(csr_hit), .event_i(event_in), .ovf_status_o(ovf_status),
        .ovf_irq_o(ovf_irq)
    );

    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after the n-th rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_access = 1'b1; csr_addr = a; csr_op = op; csr_wdata = d;
        tick(1);
        csr_access = 1'b0; csr_op = 2'b00; csr_wdata = '0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        csr_access = 1'b1; csr_addr = a; csr_op = 2'b00;
        #1;
        d = csr_rdata;
        csr_access = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] ev, input int n);
        event_in = ev;
        tick(n);
        event_in = '0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic [11:0] addrs [6] = '{12'h320, 12'h323, 12'hB03, 12'hB83, 12'h7C0, 12'h7C1};
        n_tests++; if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", ovf_irq); end
        n_tests++; if (ovf_status !== 4'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", ovf_status); end
        for (int i = 0; i < 6; i++) begin
            csr_read(addrs[i], rd);
            n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd_%h: got %h expected 0", addrs[i], rd); end
        end
        tick(1);
        csr_access = 1'b1; csr_addr = 12'h320; #1;
        n_tests++; if (csr_hit !== 1'b1) begin n_fail++; $display("FAIL hit_320: got %b expected 1", csr_hit); end
        csr_addr = 12'h321; #1;
        n_tests++; if (csr_hit !== 1'b0) begin n_fail++; $display("FAIL hit_321: got %b expected 0", csr_hit); end
        csr_addr = 12'h327; #1;
        n_tests++; if (csr_hit !== 1'b0) begin n_fail++; $display("FAIL hit_327: got %b expected 0", csr_hit); end
        csr_addr = 12'hB86; #1;
        n_tests++; if (csr_hit !== 1'b1) begin n_fail++; $display("FAIL hit_B86: got %b expected 1", csr_hit); end
        csr_access = 1'b0; csr_addr = 12'h320; #1;
        n_tests++; if (csr_hit !== 1'b0) begin n_fail++; $display("FAIL hit_noaccess: got %b expected 0", csr_hit); end
        tick(1);
    endtask

    task automatic test_count_latency;
        logic [31:0] rd;
        csr_write(12'h323, 2'b01, 32'd3);
        csr_read(12'h323, rd);
        n_tests++; if (rd !== 32'd3) begin n_fail++; $display("FAIL sel0_rd: got %h expected 3", rd); end
        pulse(16'h0004, 1);
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL latency_edge1: got %h expected 0", rd); end
        tick(1);
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL latency_edge2: got %h expected 1", rd); end
        pulse(16'h0004, 4);
        tick(2);
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'd5) begin n_fail++; $display("FAIL count5: got %h expected 5", rd); end
    endtask

    task automatic test_inhibit;
        logic [31:0] rd;
        csr_write(12'h320, 2'b01, 32'hFFFF_FFFF);
        csr_read(12'h320, rd);
        n_tests++; if (rd !== 32'h78) begin n_fail++; $display("FAIL inhibit_mask: got %h expected 78", rd); end
        csr_write(12'h320, 2'b01, 32'h8);
        pulse(16'h0004, 4);
        tick(2);
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'd5) begin n_fail++; $display("FAIL inhibited: got %h expected 5", rd); end
        csr_write(12'h320, 2'b11, 32'h8);
        csr_read(12'h320, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL inhibit_clear: got %h expected 0", rd); end
        pulse(16'h0004, 1);
        tick(1);
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'd6) begin n_fail++; $display("FAIL uninhibited: got %h expected 6", rd); end
    endtask

    task automatic test_wrap_irq;
        logic [31:0] rd;
        csr_write(12'hB83, 2'b01, 32'h1FF);
        csr_read(12'hB83, rd);
        n_tests++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL high_rd: got %h expected 000000ff", rd); end
        csr_write(12'hB03, 2'b01, 32'hFFFF_FFFF);
        csr_write(12'h7C1, 2'b10, 32'h1);
        csr_read(12'h7C1, rd);
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL enable_rd: got %h expected 1", rd); end
        n_tests++; if (ovf_status !== 4'h0) begin n_fail++; $display("FAIL ovf_no_write_set: got %h expected 0", ovf_status); end
        pulse(16'h0004, 1);
        tick(1);
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wrap_lo: got %h expected 0", rd); end
        csr_read(12'hB83, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wrap_hi: got %h expected 0", rd); end
        n_tests++; if (ovf_status !== 4'h1) begin n_fail++; $display("FAIL wrap_status: got %h expected 1", ovf_status); end
        n_tests++; if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", ovf_irq); end
        tick(1);
        n_tests++; if (ovf_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", ovf_irq); end
        csr_read(12'h7C0, rd);
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL status_rd: got %h expected 1", rd); end
        csr_write(12'h7C0, 2'b11, 32'h1);
        n_tests++; if (ovf_status !== 4'h0) begin n_fail++; $display("FAIL status_clear: got %h expected 0", ovf_status); end
        n_tests++; if (ovf_irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b expected 1", ovf_irq); end
        tick(1);
        n_tests++; if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b expected 0", ovf_irq); end
    endtask

    task automatic test_collision;
        logic [31:0] rd;
        pulse(16'h0004, 1);
        csr_write(12'hB03, 2'b01, 32'h100);
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'h100) begin n_fail++; $display("FAIL write_wins: got %h expected 100", rd); end
        // First overflow makes the flag 1, second one collides with its clear
        csr_write(12'hB83, 2'b01, 32'hFF);
        csr_write(12'hB03, 2'b01, 32'hFFFF_FFFF);
        pulse(16'h0004, 1);
        tick(1);
        n_tests++; if (ovf_status !== 4'h1) begin n_fail++; $display("FAIL second_wrap: got %h expected 1", ovf_status); end
        csr_write(12'hB83, 2'b01, 32'hFF);
        csr_write(12'hB03, 2'b01, 32'hFFFF_FFFF);
        pulse(16'h0004, 1);
        csr_write(12'h7C0, 2'b11, 32'h1);
        n_tests++; if (ovf_status !== 4'h1) begin n_fail++; $display("FAIL set_beats_clear: got %h expected 1", ovf_status); end
        csr_read(12'hB03, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL collide_wrap_lo: got %h expected 0", rd); end
    endtask

    task automatic test_selector_range;
        logic [31:0] rd;
        csr_write(12'h324, 2'b01, 32'hFFFF_FFFF);
        csr_read(12'h324, rd);
        n_tests++; if (rd !== 32'h1F) begin n_fail++; $display("FAIL sel_width: got %h expected 1f", rd); end
        csr_write(12'h324, 2'b01, 32'd17);
        csr_read(12'h324, rd);
        n_tests++; if (rd !== 32'd17) begin n_fail++; $display("FAIL sel17_rd: got %h expected 11", rd); end
        csr_write(12'h325, 2'b01, 32'd16);
        pulse(16'hFFFF, 2);
        tick(2);
        csr_read(12'hB04, rd);
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sel_oob: got %h expected 0", rd); end
        csr_read(12'hB05, rd);
        n_tests++; if (rd !== 32'd2) begin n_fail++; $display("FAIL sel16: got %h expected 2", rd); end
        csr_read(12'hB06, rd);
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sel0_none: got %h expected 0", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic [11:0] addrs [6] = '{12'h320, 12'h323, 12'hB03, 12'hB05, 12'h7C0, 12'h7C1};
        n_tests++; if (ovf_irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", ovf_irq); end
        event_in = 16'hFFFF;
        tick(1);
        rst_n = 1'b0;
        #1;
        n_tests++; if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b expected 0", ovf_irq); end
        n_tests++; if (ovf_status !== 4'h0) begin n_fail++; $display("FAIL mid_reset_status: got %h expected 0", ovf_status); end
        for (int i = 0; i < 6; i++) begin
            csr_read(addrs[i], rd);
            n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rd_%h: got %h expected 0", addrs[i], rd); end
        end
        event_in = '0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0; csr_access = 1'b0; csr_addr = '0; csr_op = 2'b00;
        csr_wdata = '0; event_in = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        test_reset;
        test_count_latency;
        test_inhibit;
        test_wrap_irq;
        test_collision;
        test_selector_range;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/zeroriscy_hpm_counters.md
# zeroriscy_hpm_counters

Parametrised hardware performance monitor for the zero-riscy core. It provides N_CNT event counters of configurable width, each with a software-selectable event source, a global inhibit mask, and sticky overflow flags that can raise an interrupt. It sits beside the CS register file and answers CSR accesses in the 0x320/0xB03/0xB83/0x7C0 ranges. The CS register file muxes in `csr_rdata_o` whenever `csr_hit_o` is high.

## Interface
- N_CNT, 4: number of counters; legal range 1..29.
- CNT_WIDTH, 40: counter width in bits; legal range 33..64.
- N_EVENTS, 16: number of event inputs; legal range 1..31.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- csr_access_i  in  1  CSR access qualifier; no hit and no write without it
- csr_addr_i  in  12  CSR address
- csr_op_i  in  2  operation: NONE=00, WRITE=01, SET=10, CLEAR=11
- csr_wdata_i  in  32  write operand
- csr_rdata_o  out  32  read data, combinational; 0 when there is no hit
- csr_hit_o  out  1  combinational; high when csr_access_i is set and the address is in the map
- event_i  in  N_EVENTS  single-cycle event pulses
- ovf_status_o  out  N_CNT  sticky overflow flags
- ovf_irq_o  out  1  registered overflow interrupt

## Operation
- Address map (i = 0..N_CNT-1):
  - 0x320 mcountinhibit: bit 3+i inhibits counter i; other bits read 0.
  - 0x323+i mhpmevent_i: 5-bit selector in bits [4:0]; upper bits read 0.
  - 0xB03+i counter i, low half: bits [31:0].
  - 0xB83+i counter i, high half: bits [CNT_WIDTH-1:32], zero-extended on read.
  - 0x7C0 ovf_status: bits [N_CNT-1:0].
  - 0x7C1 ovf_enable: bits [N_CNT-1:0].
- Write operand per op:
  - WRITE: wdata.
  - SET: q | wdata.
  - CLEAR: q & ~wdata.
  - NONE: no write.
  - Writes apply only to the implemented bits of each register.
- Event select:
  - Selector value 0 means no event.
  - Value k in 1..N_EVENTS selects event_i[k-1].
  - Values above N_EVENTS never count.
  - Reads return the stored selector value unchanged.
- Counting:
  - event_i is registered into ev_q.
  - Counter i increments by 1 when the selected ev_q bit is 1 and inhibit bit 3+i is 0.
- Wrap:
  - An increment from all-ones produces 0 and sets ovf_status[i].
  - No saturation mode.
- Write vs increment in the same cycle:
  - The CSR write wins and the increment is discarded.
  - A write to one half leaves the other half unchanged.
  - A write never sets an overflow flag.
- ovf_status is sticky and cleared only by software.
  - If a hardware set and a software clear of the same bit land in the same cycle, the set wins.
- ovf_irq_o is the registered value of |(ovf_status_q & ovf_enable_q).

## Timing
- Reset values: all counters 0, selectors 0, inhibit 0, ovf_status 0, ovf_enable 0, ev_q 0, ovf_irq_o 0.
- Event latency:
  - Pulse on event_i in cycle t → ev_q set at edge t+1 → counter updated at edge t+2.
  - Each event-cycle pulse counts exactly once.
- CSR read is combinational from current state. A read of a counter in the same cycle as an increment returns the pre-increment value.
- CSR write takes effect at the next clock edge.
- Overflow → interrupt latency:
  - Overflow increment at edge n sets ovf_status at edge n.
  - ovf_irq_o rises at edge n+1.
  - Clearing the flag or the enable drops ovf_irq_o one edge after the register update.
- Inhibit and selector changes take effect starting with the increment evaluated in the cycle after the write edge. An ev_q already latched is still gated by the new settings.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Events seen before reset release are lost.

## Test plan
- Counter count and latency: select event_i[2] for counter 0 (mhpmevent_0=3), pulse event_i[2] 5 times → counter 0 low reads 5; the first increment is visible 2 edges after the first pulse.
- Inhibit: set mcountinhibit bit 3 (0x8), pulse the selected event 4 times → counter 0 unchanged; clear the bit, pulse once → +1.
- Wrap and interrupt (CNT_WIDTH=40): write high=0xFF, low=0xFFFFFFFF, ovf_enable=1, then one event → counter reads 0, ovf_status=1, ovf_irq_o=1 one cycle later. CLEAR 0x7C0 with 1 → irq drops.
- High-half read: write high=0x1FF → read 0xB83 returns 0x000000FF.
- Collision: WRITE low=0x100 in the same cycle as an increment → reads 0x100. A hardware overflow set together with a software clear of the same flag → flag stays 1.
- Out-of-range selector and reset: set mhpmevent_1=N_EVENTS+1 and pulse all events → counter 1 stays 0. Assert rst_n mid-count → all CSRs read 0 and ovf_irq_o=0.
